// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants and state encoding for the RV32M multiply/divide sequencer.
package muldiv_sequencer_pkg;

  localparam logic [2:0] MUL_F3    = 3'b000;
  localparam logic [2:0] MULH_F3   = 3'b001;
  localparam logic [2:0] MULHSU_F3 = 3'b010;
  localparam logic [2:0] MULHU_F3  = 3'b011;
  localparam logic [2:0] DIV_F3    = 3'b100;
  localparam logic [2:0] DIVU_F3   = 3'b101;
  localparam logic [2:0] REM_F3    = 3'b110;
  localparam logic [2:0] REMU_F3   = 3'b111;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_CALC  = 2'd1,
    MD_FIXUP = 2'd2,
    MD_DONE  = 2'd3
  } md_state_e;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: shift-add multiplier and restoring divider sharing one
// 2*XLEN accumulator. Multiply leaves the product in acc; divide leaves the
// remainder in the upper half and the quotient in the lower half.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_div_mode,
  input  logic [XLEN-1:0]   i_op_a,
  input  logic [XLEN-1:0]   i_op_b,
  output logic [2*XLEN-1:0] o_acc
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic              div_q;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_cand;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;

  // One multiply step and one restoring-divide step computed side by side
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_cand = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_cand - {1'b0, b_q};
    if (div_diff[XLEN]) begin
      div_next = {div_cand[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  // Load operands on start, then advance one step per strobe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (i_load) begin
      acc_q <= {{XLEN{1'b0}}, i_op_a};
      b_q   <= i_op_b;
      div_q <= i_div_mode;
    end else if (i_step) begin
      acc_q <= div_q ? div_next : mul_next;
    end
  end

  assign o_acc = acc_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: latches operand magnitudes, runs XLEN
// iterations in the core, fixes up sign, and pulses o_done for one cycle.
import muldiv_sequencer_pkg::*;

module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic [XLEN-1:0]   result_q;

  logic              start_ok;
  logic              a_signed, b_signed, sign_a, sign_b, neg_d;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, overflow, special;
  logic [XLEN-1:0]   special_result;
  logic              core_load, core_step;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, fixup_result;

  assign start_ok = i_start & ~i_flush;

  // Operand conditioning: magnitudes, result sign and the short-circuit cases
  always_comb begin
    a_signed = (i_f3 == MULH_F3) || (i_f3 == MULHSU_F3) || (i_f3 == DIV_F3) || (i_f3 == REM_F3);
    b_signed = (i_f3 == MULH_F3) || (i_f3 == DIV_F3) || (i_f3 == REM_F3);
    sign_a   = a_signed & i_rs1[XLEN-1];
    sign_b   = b_signed & i_rs2[XLEN-1];
    abs_a    = sign_a ? -i_rs1 : i_rs1;
    abs_b    = sign_b ? -i_rs2 : i_rs2;
    neg_d    = (i_f3 == REM_F3) ? sign_a : (sign_a ^ sign_b);
    div_zero = is_div_op(i_f3) && (i_rs2 == '0);
    overflow = ((i_f3 == DIV_F3) || (i_f3 == REM_F3)) && (i_rs1 == MIN_INT) && (&i_rs2);
    special  = div_zero | overflow;
    if (div_zero) begin
      special_result = i_f3[1] ? i_rs1 : {XLEN{1'b1}};
    end else begin
      special_result = i_f3[1] ? {XLEN{1'b0}} : MIN_INT;
    end
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (core_load),
    .i_step     (core_step),
    .i_div_mode (is_div_op(i_f3)),
    .i_op_a     (abs_a),
    .i_op_b     (abs_b),
    .o_acc      (acc)
  );

  // Sign fixup and selection of the requested half or divide result
  always_comb begin
    prod = neg_q ? -acc : acc;
    quot = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fixup_result = prod[XLEN-1:0];
    case (f3_q)
      MUL_F3:                      fixup_result = prod[XLEN-1:0];
      MULH_F3, MULHSU_F3, MULHU_F3: fixup_result = prod[2*XLEN-1:XLEN];
      DIV_F3, DIVU_F3:             fixup_result = quot;
      REM_F3, REMU_F3:             fixup_result = rem;
      default:                     fixup_result = prod[XLEN-1:0];
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= MD_IDLE;
    else          state_q <= state_d;
  end

  // Next state and strobes; flush overrides everything including the done pulse
  always_comb begin
    state_d   = state_q;
    o_stall   = 1'b0;
    o_done    = 1'b0;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start_ok) begin
          o_stall   = 1'b1;
          core_load = 1'b1;
          state_d   = special ? MD_DONE : MD_CALC;
        end
      end
      MD_CALC: begin
        o_stall   = 1'b1;
        core_step = 1'b1;
        if (count_q == LAST_STEP) state_d = MD_FIXUP;
      end
      MD_FIXUP: begin
        o_stall = 1'b1;
        state_d = MD_DONE;
      end
      MD_DONE: begin
        o_done  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (i_flush) begin
      state_d   = MD_IDLE;
      o_done    = 1'b0;
      core_load = 1'b0;
      core_step = 1'b0;
    end
  end

  // Operation bookkeeping: funct3, result sign, step counter and result register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q  <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      if (state_q == MD_IDLE && start_ok) begin
        f3_q    <= i_f3;
        neg_q   <= neg_d;
        count_q <= '0;
        if (special) result_q <= special_result;
      end
      if (state_q == MD_CALC) count_q <= count_q + CNT_W'(1);
      if (state_q == MD_FIXUP && !i_flush) result_q <= fixup_result;
    end
  end

  assign o_result = result_q;

endmodule
